// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, decode redirects with one-deep pending capture under stall.
// SRAM address is pc_q, with 1-cycle read latency; stall[0] freezes PC/ce and parks the oldest redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        if_adel,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    PEND = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  logic        hold;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign hold         = stall[0];
  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[5:1];

  // A parked redirect always outranks a live one: oldest redirect wins.
  assign next_pc = pend_v_q ? pend_addr_q :
                   br_e     ? br_addr     :
                              pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ce_d           = ce_q;
    pend_v_d       = pend_v_q;
    pend_addr_d    = pend_addr_q;
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    if (ce_q && !hold) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    case (state_q)
      BOOT: begin
        pc_d    = RESET_PC + 32'd4;
        ce_d    = 1'b1;
        state_d = RUN;
      end
      default: begin
        if (!hold) begin
          pc_d     = next_pc;
          pend_v_d = 1'b0;
          state_d  = RUN;
          if (pend_v_q || br_e) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
          end
        end else begin
          if (br_e && !pend_v_q) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
          end
          state_d = pend_v_d ? PEND : HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      ce_q           <= 1'b0;
      pend_v_q       <= 1'b0;
      pend_addr_q    <= 32'd0;
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ce_q           <= ce_d;
      pend_v_q       <= pend_v_d;
      pend_addr_q    <= pend_addr_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Misaligned PCs are still presented to decode but never reach the SRAM.
  assign if_adel         = ce_q & (pc_q[1:0] != 2'b00);
  assign inst_sram_en    = ce_q & ~if_adel;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_q, pc_q};
  assign fetch_cnt       = fetch_cnt_q;
  assign redirect_cnt    = redirect_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference model pushes expected outputs per driven cycle.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'hBFBF_FFFC;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_adel;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .if_adel        (if_adel),
    .fetch_cnt      (fetch_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] bus;
    logic        en;
    logic        adel;
    logic [31:0] fc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];

  int n_vec;
  int n_err;

  // reference model state
  logic [31:0] m_pc, m_pa, m_fc, m_rc;
  logic        m_ce, m_pv, m_boot;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [5:0] s, input logic [32:0] b);
    exp_t e;
    if (r) begin
      m_pc = RPC; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'd0;
      m_boot = 1'b1; m_fc = 32'd0; m_rc = 32'd0;
    end else if (m_boot) begin
      m_pc = RPC + 32'd4; m_ce = 1'b1; m_boot = 1'b0;
    end else if (!s[0]) begin
      if (m_ce) m_fc = m_fc + 32'd1;
      if (m_pv) begin
        m_pc = m_pa; m_rc = m_rc + 32'd1;
      end else if (b[32]) begin
        m_pc = b[31:0]; m_rc = m_rc + 32'd1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pv = 1'b0;
    end else if (b[32] && !m_pv) begin
      m_pv = 1'b1; m_pa = b[31:0];
    end
    e.bus  = {m_ce, m_pc};
    e.adel = m_ce && (m_pc[1:0] != 2'b00);
    e.en   = m_ce && !e.adel;
    e.fc   = m_fc;
    e.rc   = m_rc;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then compare DUT outputs against the queued expectation.
  task automatic step(input logic r, input logic [5:0] s, input logic [32:0] b);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br_bus = b;
    model_edge(r, s, b);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("sb_bus",   {31'd0, if_to_id_bus}, {31'd0, e.bus});
      check_val("sb_en",    {63'd0, inst_sram_en}, {63'd0, e.en});
      check_val("sb_adel",  {63'd0, if_adel},      {63'd0, e.adel});
      check_val("sb_fcnt",  {32'd0, fetch_cnt},    {32'd0, e.fc});
      check_val("sb_rcnt",  {32'd0, redirect_cnt}, {32'd0, e.rc});
      check_val("sb_addr",  {32'd0, inst_sram_addr}, {32'd0, e.bus[31:0]});
      check_val("sb_wen",   {60'd0, inst_sram_wen},   64'd0);
      check_val("sb_wdata", {32'd0, inst_sram_wdata}, 64'd0);
    end
  endtask

  localparam logic [32:0] NOBR = 33'd0;

  function automatic logic [32:0] br(input logic [31:0] a);
    return {1'b1, a};
  endfunction

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; stall = 6'd0; br_bus = NOBR;
    m_pc = RPC; m_pa = 32'd0; m_fc = 32'd0; m_rc = 32'd0;
    m_ce = 1'b0; m_pv = 1'b0; m_boot = 1'b1;

    // reset for 3 cycles with noise on stall/br_bus
    step(1'b1, 6'b000001, br(32'hDEAD_BEE0));
    step(1'b1, 6'b101010, NOBR);
    step(1'b1, 6'b000000, br(32'h1234_5678));
    check_val("rst_bus",  {31'd0, if_to_id_bus}, {31'd0, 1'b0, 32'hBFBF_FFFC});
    check_val("rst_en",   {63'd0, inst_sram_en}, 64'd0);
    check_val("rst_adel", {63'd0, if_adel},      64'd0);
    check_val("rst_cnt",  {fetch_cnt, redirect_cnt}, 64'd0);

    // boot sequence
    step(1'b0, 6'd0, NOBR);
    check_val("boot_pc1", {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0000);
    check_val("boot_ce1", {63'd0, if_to_id_bus[32]},   64'd1);
    check_val("boot_en1", {63'd0, inst_sram_en},       64'd1);
    step(1'b0, 6'd0, NOBR);
    check_val("boot_pc2", {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0004);
    step(1'b0, 6'd0, NOBR);
    check_val("boot_fcnt", {32'd0, fetch_cnt}, 64'd2);
    check_val("boot_pc3",  {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0008);

    // single redirect
    step(1'b0, 6'd0, br(32'hBFC0_0100));
    check_val("redir_pc",  {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0100);
    check_val("redir_cnt", {32'd0, redirect_cnt}, 64'd1);

    // stalled redirect, second redirect ignored
    step(1'b0, 6'b000001, br(32'hBFC0_0200));
    step(1'b0, 6'b000001, br(32'hBFC0_0300));
    step(1'b0, 6'b000001, NOBR);
    check_val("stall_pc",    {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0100);
    check_val("stall_state", {62'd0, dut.state_q}, 64'd3);
    step(1'b0, 6'd0, NOBR);
    check_val("rel_pc",   {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0200);
    check_val("rel_pv",   {63'd0, dut.pend_v_q}, 64'd0);
    check_val("rel_rcnt", {32'd0, redirect_cnt}, 64'd2);

    // release collision: pending wins over live redirect
    step(1'b0, 6'b000001, br(32'hBFC0_0400));
    step(1'b0, 6'd0, br(32'hBFC0_0500));
    check_val("coll_pc",   {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0400);
    check_val("coll_rcnt", {32'd0, redirect_cnt}, 64'd3);

    // misaligned redirect
    step(1'b0, 6'd0, br(32'hBFC0_0102));
    check_val("mis_pc",   {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0102);
    check_val("mis_adel", {63'd0, if_adel}, 64'd1);
    check_val("mis_en",   {63'd0, inst_sram_en}, 64'd0);
    check_val("mis_ce",   {63'd0, if_to_id_bus[32]}, 64'd1);
    step(1'b0, 6'd0, NOBR);
    check_val("mis_pc2",   {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0106);
    check_val("mis_adel2", {63'd0, if_adel}, 64'd1);

    // PC wrap at top of address space
    step(1'b0, 6'd0, br(32'hFFFF_FFFC));
    step(1'b0, 6'd0, NOBR);
    check_val("wrap_pc", {32'd0, if_to_id_bus[31:0]}, 64'd0);

    // randomized traffic through the scoreboard
    for (int i = 0; i < 300; i++) begin
      logic [5:0]  s;
      logic [31:0] a;
      s = 6'($urandom);
      a = {20'hBFC00, 10'($urandom), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
      step(1'b0, s, ($urandom_range(0, 3) == 0) ? br(a) : NOBR);
    end

    // reset while a redirect is parked
    step(1'b0, 6'd0, br(32'hBFC0_0010));
    step(1'b0, 6'b000001, br(32'hBFC0_0600));
    check_val("pre_rst_state", {62'd0, dut.state_q}, 64'd3);
    step(1'b1, 6'b000001, NOBR);
    check_val("mrst_bus", {31'd0, if_to_id_bus}, {31'd0, 1'b0, 32'hBFBF_FFFC});
    check_val("mrst_cnt", {fetch_cnt, redirect_cnt}, 64'd0);
    step(1'b0, 6'd0, NOBR);
    check_val("mrst_first", {32'd0, if_to_id_bus[31:0]}, 64'hBFC0_0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 6'd0, NOBR);
      check_val("mrst_no_stale", {63'd0, if_to_id_bus[31:0] == 32'hBFC0_0600}, 64'd0);
    end
    check_val("mrst_rcnt", {32'd0, redirect_cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
